// File: rtl/rom_uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : rom_uart_sender
// Purpose  : Streams a fixed message out of a 64x8 single-port message ROM
//            onto a UART TX line (8N1, LSB first). One start pulse sends the
//            bytes at addresses 0..MSG_LEN-1. When STOP_ON_ZERO is set, a
//            0x00 byte ends the message early and is not transmitted.
// Ports    : clka      in   system clock, rising edge
//            rsta_n    in   asynchronous active-low reset
//            start     in   message request, honoured in IDLE only
//            rom_addr  out  ROM address (to ROM addra)
//            rom_rst   out  ROM synchronous reset, follows ~rsta_n
//            rom_dout  in   ROM data (from ROM doa), valid 1 cycle after addr
//            txd       out  UART serial output, idle high
//            busy      out  high while a message is in progress
//            done      out  one-cycle pulse when a message finishes
// Revision : 1.0 - initial release
// ============================================================================
module rom_uart_sender #(
  parameter int BAUD_DIV     = 208,
  parameter int MSG_LEN      = 64,
  parameter int STOP_ON_ZERO = 1
) (
  input  logic       clka,
  input  logic       rsta_n,
  input  logic       start,
  output logic [5:0] rom_addr,
  output logic       rom_rst,
  input  logic [7:0] rom_dout,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int                  c_BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
  localparam logic [5:0]          c_LAST_IDX  = 6'(MSG_LEN - 1);
  localparam logic [3:0]          c_STOP_SLOT = 4'd9;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_FETCH = 3'd1;
  localparam logic [2:0] c_ST_LOAD  = 3'd2;
  localparam logic [2:0] c_ST_SEND  = 3'd3;
  localparam logic [2:0] c_ST_NEXT  = 3'd4;
  localparam logic [2:0] c_ST_FIN   = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [5:0]          addr_q,  addr_d;
  logic [5:0]          idx_q,   idx_d;
  logic [c_BAUD_W-1:0] baud_q,  baud_d;
  logic [3:0]          slot_q,  slot_d;   // 0 start, 1..8 data, 9 stop
  logic [7:0]          shift_q, shift_d;
  logic                txd_q,   txd_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  // The ROM reset simply mirrors our own reset.
  assign rom_rst  = ~rsta_n;
  assign rom_addr = addr_q;
  assign txd      = txd_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= c_ST_IDLE;
      addr_q  <= 6'd0;
      idx_q   <= 6'd0;
      baud_q  <= '0;
      slot_q  <= 4'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      baud_q  <= baud_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    baud_d  = baud_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start) begin
          addr_d  = 6'd0;
          idx_d   = 6'd0;
          state_d = c_ST_FETCH;
        end
      end
      // ROM samples addr_q at the end of this cycle.
      c_ST_FETCH: state_d = c_ST_LOAD;
      c_ST_LOAD: begin
        shift_d = rom_dout;
        if ((STOP_ON_ZERO != 0) && (rom_dout == 8'h00)) begin
          state_d = c_ST_FIN;
        end else begin
          slot_d  = 4'd0;
          baud_d  = '0;
          state_d = c_ST_SEND;
        end
      end
      c_ST_SEND: begin
        if (baud_q == c_BAUD_LAST) begin
          baud_d = '0;
          if (slot_q == c_STOP_SLOT) begin
            state_d = c_ST_NEXT;
          end else begin
            slot_d = slot_q + 4'd1;
            // Leaving a data slot exposes the next data bit at shift[0];
            // leaving the start slot keeps data[0] in place.
            if (slot_q != 4'd0) begin
              shift_d = {1'b0, shift_q[7:1]};
            end
          end
        end else begin
          baud_d = baud_q + c_BAUD_ONE;
        end
      end
      c_ST_NEXT: begin
        if (idx_q == c_LAST_IDX) begin
          state_d = c_ST_FIN;
        end else begin
          idx_d   = idx_q + 6'd1;
          addr_d  = addr_q + 6'd1;
          state_d = c_ST_FETCH;
        end
      end
      c_ST_FIN: state_d = c_ST_IDLE;
      default:  state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: decoded from the next state so the registered outputs line
  // up exactly with the state they describe (no path from rom_dout to txd
  // other than through shift_q/shift_d into a flop).
  // --------------------------------------------------------------------------
  always_comb begin
    txd_d  = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      c_ST_FETCH, c_ST_LOAD, c_ST_NEXT: busy_d = 1'b1;
      c_ST_SEND: begin
        busy_d = 1'b1;
        if (slot_d == 4'd0) begin
          txd_d = 1'b0;
        end else if (slot_d == c_STOP_SLOT) begin
          txd_d = 1'b1;
        end else begin
          txd_d = shift_d[0];
        end
      end
      c_ST_FIN: done_d = 1'b1;
      default: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_uart_sender
// Purpose  : Self-checking bench for rom_uart_sender. Three instances:
//            0: BAUD_DIV=4, MSG_LEN=3,  STOP_ON_ZERO=0, ROM 41 42 43 00..
//            1: BAUD_DIV=4, MSG_LEN=8,  STOP_ON_ZERO=1, ROM 41 42 43 00..
//            2: BAUD_DIV=2, MSG_LEN=64, STOP_ON_ZERO=1, ROM[i]=i+1
//            A UART receiver per instance pops expected bytes from a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_uart_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v   [3];
  logic [5:0] addr_v    [3];
  logic       rom_rst_v [3];
  logic [7:0] dout_v    [3];
  logic       txd_v     [3];
  logic       busy_v    [3];
  logic       done_v    [3];
  logic [7:0] rom       [3][64];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  int         done_cnt  [3] = '{0, 0, 0};
  int         n_pass  = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  // ROM models (1-cycle registered read) and done-pulse counters.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      dout_v[k] <= rom_rst_v[k] ? 8'h00 : rom[k][addr_v[k]];
      if (done_v[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
  endtask

  task automatic score(input int g, input logic [7:0] b);
    int         sz;
    logic [7:0] e;
    e = 8'h00;
    case (g)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    chk($sformatf("dut%0d_frame_expected", g), (sz > 0) ? 1 : 0, 1);
    if (sz > 0) begin
      case (g)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      chk($sformatf("dut%0d_rx_byte", g), b, e);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int B = (g == 2) ? 2 : 4;
    localparam int L = (g == 0) ? 3 : ((g == 1) ? 8 : 64);
    localparam int S = (g == 0) ? 0 : 1;

    rom_uart_sender #(.BAUD_DIV(B), .MSG_LEN(L), .STOP_ON_ZERO(S)) u_dut (
      .clka    (clk),
      .rsta_n  (rst_n),
      .start   (start_v[g]),
      .rom_addr(addr_v[g]),
      .rom_rst (rom_rst_v[g]),
      .rom_dout(dout_v[g]),
      .txd     (txd_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g])
    );

    // UART receiver: samples mid-slot, counting clocks from the falling edge.
    initial begin : p_mon
      logic [7:0] b;
      logic       sb;
      logic       stp;
      bit         abort;
      forever begin
        @(negedge txd_v[g]);
        if (rst_n === 1'b1) begin
          abort = 1'b0;
          b     = 8'h00;
          sb    = 1'b1;
          stp   = 1'b0;
          for (int t = 1; t <= B / 2 + 9 * B; t++) begin
            @(posedge clk);
            #2;
            if (rst_n !== 1'b1) abort = 1'b1;
            if (t >= B / 2 && ((t - B / 2) % B) == 0) begin
              case ((t - B / 2) / B)
                0:       sb  = txd_v[g];
                9:       stp = txd_v[g];
                default: b[((t - B / 2) / B) - 1] = txd_v[g];
              endcase
            end
          end
          if (!abort) begin
            chk($sformatf("dut%0d_start_bit", g), sb, 0);
            chk($sformatf("dut%0d_stop_bit", g), stp, 1);
            score(g, b);
          end
        end
      end
    end
  end

  typedef struct {
    int         cyc;
    bit         drv_start;
    bit         push;
    bit         e_txd;
    bit         e_busy;
    bit         e_done;
    logic [5:0] e_addr;
  } vec_t;

  function automatic vec_t mk(int c, bit s, bit p, bit t, bit b, bit d, int a);
    vec_t v;
    v.cyc = c; v.drv_start = s; v.push = p;
    v.e_txd = t; v.e_busy = b; v.e_done = d; v.e_addr = 6'(a);
    return v;
  endfunction

  initial begin : p_main
    vec_t tab [26];
    int   j;
    int   cyc;
    int   d0;

    // cycle, start driven after edge, push message, txd, busy, done, addr
    tab[0]  = mk(0,   1, 1, 1, 0, 0, 0);
    tab[1]  = mk(1,   0, 0, 1, 1, 0, 0);
    tab[2]  = mk(2,   0, 0, 1, 1, 0, 0);
    tab[3]  = mk(3,   0, 0, 0, 1, 0, 0);
    tab[4]  = mk(6,   0, 0, 0, 1, 0, 0);
    tab[5]  = mk(7,   0, 0, 1, 1, 0, 0);
    tab[6]  = mk(10,  1, 0, 1, 1, 0, 0);
    tab[7]  = mk(11,  0, 0, 0, 1, 0, 0);
    tab[8]  = mk(31,  0, 0, 1, 1, 0, 0);
    tab[9]  = mk(35,  0, 0, 0, 1, 0, 0);
    tab[10] = mk(39,  0, 0, 1, 1, 0, 0);
    tab[11] = mk(43,  0, 0, 1, 1, 0, 0);
    tab[12] = mk(44,  0, 0, 1, 1, 0, 1);
    tab[13] = mk(45,  1, 0, 1, 1, 0, 1);
    tab[14] = mk(46,  0, 0, 0, 1, 0, 1);
    tab[15] = mk(50,  0, 0, 0, 1, 0, 1);
    tab[16] = mk(54,  0, 0, 1, 1, 0, 1);
    tab[17] = mk(88,  0, 0, 1, 1, 0, 2);
    tab[18] = mk(89,  0, 0, 0, 1, 0, 2);
    tab[19] = mk(93,  0, 0, 1, 1, 0, 2);
    tab[20] = mk(129, 0, 0, 1, 1, 0, 2);
    tab[21] = mk(130, 1, 0, 1, 0, 1, 2);
    tab[22] = mk(131, 1, 1, 1, 0, 0, 2);
    tab[23] = mk(132, 0, 0, 1, 1, 0, 0);
    tab[24] = mk(261, 0, 0, 1, 0, 1, 2);
    tab[25] = mk(262, 0, 0, 1, 0, 0, 2);

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom[0][i] = (i < 3) ? 8'(8'h41 + i) : 8'h00;
      rom[1][i] = (i < 3) ? 8'(8'h41 + i) : 8'h00;
      rom[2][i] = 8'(i + 1);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_txd%0d", k), txd_v[k], 1);
      chk($sformatf("reset_busy%0d", k), busy_v[k], 0);
      chk($sformatf("reset_done%0d", k), done_v[k], 0);
      chk($sformatf("reset_addr%0d", k), addr_v[k], 0);
      chk($sformatf("reset_rom_rst%0d", k), rom_rst_v[k], 1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rom_rst_released", rom_rst_v[0], 0);

    // ---- instance 0: timing table, start ignored while busy / in FIN ----
    d0 = done_cnt[0];
    j  = 0;
    for (int c = 0; c <= 262; c++) begin
      @(posedge clk);
      #1;
      if (j < 26 && tab[j].cyc == c) begin
        chk($sformatf("tab_txd_c%0d", c), txd_v[0], tab[j].e_txd);
        chk($sformatf("tab_busy_c%0d", c), busy_v[0], tab[j].e_busy);
        chk($sformatf("tab_done_c%0d", c), done_v[0], tab[j].e_done);
        chk($sformatf("tab_addr_c%0d", c), addr_v[0], tab[j].e_addr);
        start_v[0] = tab[j].drv_start;
        if (tab[j].push) begin
          exp_q0.push_back(8'h41); exp_q0.push_back(8'h42); exp_q0.push_back(8'h43);
        end
        j++;
      end else begin
        start_v[0] = 1'b0;
      end
    end
    chk("dut0_done_pulses", done_cnt[0] - d0, 2);
    chk("dut0_queue_empty", exp_q0.size(), 0);

    // ---- instance 0: reset during data bit of byte 1, then resend ----
    start_v[0] = 1'b1;
    exp_q0.push_back(8'h41); exp_q0.push_back(8'h42); exp_q0.push_back(8'h43);
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (59) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_txd", txd_v[0], 1);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_addr", addr_v[0], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q0.delete();
    d0 = done_cnt[0];
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt[0] - d0, 0);
    chk("midrst_idle_txd", txd_v[0], 1);
    start_v[0] = 1'b1;
    exp_q0.push_back(8'h41); exp_q0.push_back(8'h42); exp_q0.push_back(8'h43);
    cyc = 0;
    while (cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      start_v[0] = 1'b0;
      if (cyc == 1) chk("resend_addr0", addr_v[0], 0);
      if (done_v[0] === 1'b1) break;
    end
    chk("resend_done_cycle", cyc, 130);
    repeat (3) @(posedge clk);
    #1;
    chk("resend_queue_empty", exp_q0.size(), 0);

    // ---- instance 1: stop on terminator at address 3 ----
    d0 = done_cnt[1];
    start_v[1] = 1'b1;
    exp_q1.push_back(8'h41); exp_q1.push_back(8'h42); exp_q1.push_back(8'h43);
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      start_v[1] = 1'b0;
      if (done_v[1] === 1'b1) break;
    end
    chk("term3_done_cycle", cyc, 132);
    chk("term3_addr", addr_v[1], 3);
    chk("term3_busy", busy_v[1], 0);
    @(posedge clk);
    #1;
    chk("term3_done_low", done_v[1], 0);
    chk("term3_done_pulses", done_cnt[1] - d0, 1);
    chk("term3_queue_empty", exp_q1.size(), 0);

    // ---- instance 1: terminator at address 0 sends nothing ----
    rom[1][0] = 8'h00;
    d0 = done_cnt[1];
    start_v[1] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      start_v[1] = 1'b0;
      chk($sformatf("term0_txd_c%0d", c), txd_v[1], 1);
      chk($sformatf("term0_busy_c%0d", c), busy_v[1], (c < 3) ? 1 : 0);
      chk($sformatf("term0_done_c%0d", c), done_v[1], (c == 3) ? 1 : 0);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("term0_txd_after", txd_v[1], 1);
    chk("term0_addr", addr_v[1], 0);
    chk("term0_done_pulses", done_cnt[1] - d0, 1);

    // ---- instance 2: full 64-byte message, BAUD_DIV=2 ----
    d0 = done_cnt[2];
    start_v[2] = 1'b1;
    for (int i = 1; i <= 64; i++) exp_q2.push_back(8'(i));
    cyc = 0;
    while (cyc < 1600) begin
      @(posedge clk);
      #1;
      cyc++;
      start_v[2] = 1'b0;
      if (done_v[2] === 1'b1) break;
    end
    chk("full_done_cycle", cyc, 64 * 23 + 1);
    chk("full_last_addr", addr_v[2], 63);
    repeat (3) @(posedge clk);
    #1;
    chk("full_done_pulses", done_cnt[2] - d0, 1);
    chk("full_queue_empty", exp_q2.size(), 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
